gshare_bp_multi: RTL and testbench

Parametrised single-clock g-share branch predictor for the rtf65004 front end. It gives one taken/not-taken prediction per fetch slot from a table of 2-bit saturating counters, indexed by the fetch address XORed with a global history register. Up to CPORTS commit-side branch outcomes per cycle enter an update queue, which drains one entry per cycle into the table. After reset, a sweep state machine initialises every table entry.

---
 rtl/gshare_bp_multi.sv | 200 ++++++++++++++++++++
 tb/tb_gshare_bp_multi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_bp_multi.sv
// gshare_bp_multi: multi-slot g-share branch predictor with a commit update queue.
// A table of 2-bit saturating counters is indexed by addr[IDXW-1:0] ^ addr[2*IDXW-1:IDXW],
// XORed with the global history when MODE = 1. After reset an init sweep writes CTR_INIT
// into every entry. Committed branches are queued, and one queued entry is drained per cycle.
// Ports:
//   clk, rst_n     core clock, asynchronous active-low reset
//   en             predictor enable (gates predictions and table/history updates)
//   hist_clr       synchronous clear of the global history
//   commit_v/_takb/_ip  per-port committed branch valid, outcome and address
//   ip             fetch address per slot
//   predict_taken  combinational taken prediction per slot
//   ready          init sweep complete
//   q_count        update queue occupancy
//   ovf_cnt        saturating count of dropped updates
module gshare_bp_multi #(
  parameter int unsigned AMSB     = 63,
  parameter int unsigned FSLOTS   = 4,
  parameter int unsigned CPORTS   = 4,
  parameter int unsigned TBLSZ    = 4096,
  parameter int unsigned HISTLEN  = 8,
  parameter int unsigned QDEPTH   = 16,
  parameter int unsigned MODE     = 1,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          hist_clr,
  input  logic [CPORTS-1:0]             commit_v,
  input  logic [CPORTS-1:0]             commit_takb,
  input  logic [CPORTS-1:0][AMSB:0]     commit_ip,
  input  logic [FSLOTS-1:0][AMSB:0]     ip,
  output logic [FSLOTS-1:0]             predict_taken,
  output logic                          ready,
  output logic [$clog2(QDEPTH):0]       q_count,
  output logic [15:0]                   ovf_cnt
);

  localparam int unsigned IDXW = $clog2(TBLSZ);
  localparam int unsigned HW   = 2 * IDXW;
  localparam int unsigned QAW  = $clog2(QDEPTH);
  localparam int unsigned PW   = QAW + 1;
  localparam int unsigned HSH  = IDXW - HISTLEN;

  // Only the address bits that feed the index are kept in the queue.
  typedef struct packed {
    logic          takb;
    logic [HW-1:0] ip;
  } upd_t;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nx;
  logic              sweep_we, drain_ok;
  logic [IDXW-1:0]   wa;
  logic [HISTLEN-1:0] ghr;
  logic [1:0]        tbl [TBLSZ];
  upd_t              q_mem [QDEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     free_slots, n_push;
  logic [15:0]       n_drop;
  logic [16:0]       ovf_sum;
  logic [CPORTS-1:0] push_we;
  logic [QAW-1:0]    push_addr [CPORTS];
  logic              pop, drain_we;
  upd_t              head;
  logic [IDXW-1:0]   didx;
  logic [1:0]        ctr_cur, ctr_nx;
  logic              unused_ip;

  function automatic logic [IDXW-1:0] idx_of(input logic [HW-1:0] a, input logic [HISTLEN-1:0] h);
    logic [IDXW-1:0] hs;
    hs = (MODE != 0) ? (IDXW'(h) << HSH) : '0;
    return a[IDXW-1:0] ^ a[HW-1:IDXW] ^ hs;
  endfunction

  // State register; ready tracks the state it is entering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      ready <= 1'b0;
    end else begin
      state <= state_nx;
      ready <= (state_nx == S_RUN);
    end
  end

  // Next state: leave INIT once the last entry is being written.
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (wa == IDXW'(TBLSZ - 1)) state_nx = S_RUN;
      S_RUN:   state_nx = S_RUN;
      default: state_nx = S_INIT;
    endcase
  end

  // State outputs: sweep writes in INIT, drain allowed in RUN.
  always_comb begin
    sweep_we = 1'b0;
    drain_ok = 1'b0;
    case (state)
      S_INIT:  sweep_we = 1'b1;
      S_RUN:   drain_ok = 1'b1;
      default: ;
    endcase
  end

  // Sweep address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        wa <= '0;
    else if (sweep_we) wa <= wa + IDXW'(1);
  end

  // Enqueue: lowest valid ports fill the free slots contiguously, the rest are dropped.
  assign free_slots = PW'(QDEPTH) - q_count;

  always_comb begin
    n_push  = '0;
    n_drop  = '0;
    push_we = '0;
    for (int k = 0; k < CPORTS; k++) begin
      push_addr[k] = '0;
      if (commit_v[k]) begin
        if (n_push < free_slots) begin
          push_we[k]   = 1'b1;
          push_addr[k] = wr_ptr[QAW-1:0] + n_push[QAW-1:0];
          n_push       = n_push + PW'(1);
        end else begin
          n_drop = n_drop + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < CPORTS; k++) begin
      if (push_we[k]) q_mem[push_addr[k]] <= '{takb: commit_takb[k], ip: commit_ip[k][HW-1:0]};
    end
  end

  // Drain: head counter update using the current history.
  assign pop      = drain_ok && (q_count != '0);
  assign drain_we = pop && en;
  assign head     = q_mem[rd_ptr[QAW-1:0]];
  assign didx     = idx_of(head.ip, ghr);
  assign ctr_cur  = tbl[didx];

  always_comb begin
    ctr_nx = ctr_cur;
    if (head.takb) begin
      if (ctr_cur != 2'b11) ctr_nx = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_nx = ctr_cur - 2'b01;
    end
  end

  assign ovf_sum = 17'(ovf_cnt) + 17'(n_drop);

  // Queue pointers, occupancy, overflow count and global history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      ovf_cnt <= '0;
      ghr     <= '0;
    end else begin
      wr_ptr  <= wr_ptr + n_push;
      rd_ptr  <= rd_ptr + PW'(pop);
      q_count <= q_count + n_push - PW'(pop);
      ovf_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
      // Clear wins over the shift; the table write above still used the old history.
      if (hist_clr)      ghr <= '0;
      else if (drain_we) ghr <= HISTLEN'({ghr, head.takb});
    end
  end

  // Counter table: single write port shared by the sweep and the drain.
  always_ff @(posedge clk) begin
    if (sweep_we)      tbl[wa]   <= CTR_INIT;
    else if (drain_we) tbl[didx] <= ctr_nx;
  end

  // Predictions read the pre-write table contents.
  always_comb begin
    predict_taken = '0;
    for (int n = 0; n < FSLOTS; n++) begin
      predict_taken[n] = tbl[idx_of(ip[n][HW-1:0], ghr)][1] & en & ready;
    end
  end

  // Address bits above the index field do not affect the predictor.
  always_comb begin
    unused_ip = 1'b0;
    for (int n = 0; n < FSLOTS; n++) unused_ip = unused_ip ^ (^ip[n][AMSB:HW]);
    for (int k = 0; k < CPORTS; k++) unused_ip = unused_ip ^ (^commit_ip[k][AMSB:HW]);
  end

endmodule

// File: tb/tb_gshare_bp_multi.sv
// Self-checking bench for gshare_bp_multi (TBLSZ=64, HISTLEN=4, QDEPTH=4, MODE=1).
// Stimulus pushes expected values into a scoreboard; a monitor compares them on the falling edge.
module tb_gshare_bp_multi;

  localparam int unsigned AMSB   = 63;
  localparam int unsigned FSLOTS = 4;
  localparam int unsigned CPORTS = 4;
  localparam int unsigned QDEPTH = 4;
  localparam int unsigned QCW    = $clog2(QDEPTH) + 1;

  localparam int unsigned SEL_PRED  = 0;
  localparam int unsigned SEL_READY = 1;
  localparam int unsigned SEL_QCNT  = 2;
  localparam int unsigned SEL_OVF   = 3;

  logic                      clk = 1'b0;
  logic                      rst_n, en, hist_clr;
  logic [CPORTS-1:0]         commit_v, commit_takb;
  logic [CPORTS-1:0][AMSB:0] commit_ip;
  logic [FSLOTS-1:0][AMSB:0] ip;
  logic [FSLOTS-1:0]         predict_taken;
  logic                      ready;
  logic [QCW-1:0]            q_count;
  logic [15:0]               ovf_cnt;

  always #5 clk = ~clk;

  gshare_bp_multi #(
    .AMSB(AMSB), .FSLOTS(FSLOTS), .CPORTS(CPORTS), .TBLSZ(64), .HISTLEN(4),
    .QDEPTH(QDEPTH), .MODE(1), .CTR_INIT(2'b01)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hist_clr(hist_clr),
    .commit_v(commit_v), .commit_takb(commit_takb), .commit_ip(commit_ip),
    .ip(ip), .predict_taken(predict_taken), .ready(ready),
    .q_count(q_count), .ovf_cnt(ovf_cnt)
  );

  typedef struct {
    int unsigned sel;
    int unsigned exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic expect_out(input int unsigned sel, input int unsigned exp, input string name);
    chk_t c;
    c.sel  = sel;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  always @(negedge clk) begin : monitor
    chk_t        c;
    int unsigned act;
    while (sb.size() != 0) begin
      c = sb.pop_front();
      case (c.sel)
        SEL_PRED:  act = 32'(predict_taken);
        SEL_READY: act = 32'(ready);
        SEL_QCNT:  act = 32'(q_count);
        default:   act = 32'(ovf_cnt);
      endcase
      n_checks++;
      if (act == c.exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_slots(input logic [AMSB:0] a0, input logic [AMSB:0] a1,
                           input logic [AMSB:0] a2, input logic [AMSB:0] a3);
    ip[0] = a0;
    ip[1] = a1;
    ip[2] = a2;
    ip[3] = a3;
  endtask

  // One commit on port 0 with an empty queue: enqueue edge, then drain edge.
  task automatic upd(input logic [AMSB:0] a, input logic t, input logic hc1, input logic hc2,
                     input logic [3:0] pb, input logic [3:0] pa, input string nm);
    commit_v       = 4'b0001;
    commit_takb    = {3'b000, t};
    commit_ip[0]   = a;
    hist_clr       = hc1;
    step();
    commit_v       = '0;
    hist_clr       = hc2;
    expect_out(SEL_PRED, 32'(pb), {nm, "_pre"});
    step();
    expect_out(SEL_PRED, 32'(pa), {nm, "_post"});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    rst_n       = 1'b0;
    en          = 1'b1;
    hist_clr    = 1'b0;
    commit_v    = '0;
    commit_takb = '0;
    commit_ip   = '0;
    set_slots(64'h100, 64'h100, 64'h100, 64'h100);

    step();
    expect_out(SEL_READY, 0, "rst_ready");
    expect_out(SEL_QCNT,  0, "rst_qcount");
    expect_out(SEL_OVF,   0, "rst_ovf");
    expect_out(SEL_PRED,  0, "rst_pred");
    settle();

    // Fill the queue during INIT and overflow it.
    rst_n = 1'b1;
    for (int k = 0; k < CPORTS; k++) commit_ip[k] = 64'h100;
    commit_v    = 4'b0111;
    commit_takb = 4'b0111;
    step();
    expect_out(SEL_QCNT, 3, "push3_qcount");
    expect_out(SEL_OVF,  0, "push3_ovf");
    commit_v    = 4'b1111;
    commit_takb = 4'b1111;
    step();
    expect_out(SEL_QCNT, 4, "ovf_qcount");
    expect_out(SEL_OVF,  3, "ovf_cnt3");
    commit_v = 4'b0011;
    step();
    expect_out(SEL_QCNT,  4, "full_qcount");
    expect_out(SEL_OVF,   5, "full_ovf5");
    expect_out(SEL_READY, 0, "init_ready_e3");
    commit_v = '0;
    for (int i = 4; i <= 63; i++) step();
    expect_out(SEL_READY, 0, "init_ready_e63");
    expect_out(SEL_QCNT,  4, "init_nodrain");

    // Sweep finishes; drain with en = 0 discards entries.
    en = 1'b0;
    step();
    expect_out(SEL_READY, 1, "ready_e64");
    expect_out(SEL_QCNT,  4, "run_qcount_e64");
    expect_out(SEL_PRED,  0, "en0_pred");
    commit_v    = 4'b0001;
    commit_takb = 4'b0001;
    step();
    expect_out(SEL_QCNT, 3, "pop_full_drop_q");
    expect_out(SEL_OVF,  6, "pop_full_drop_ovf");
    step();
    expect_out(SEL_QCNT, 3, "push_pop_q");
    expect_out(SEL_OVF,  6, "push_pop_ovf");
    commit_v = '0;
    step();
    expect_out(SEL_QCNT, 2, "en0_q2");
    step();
    expect_out(SEL_QCNT, 1, "en0_q1");
    step();
    expect_out(SEL_QCNT, 0, "en0_q0");
    expect_out(SEL_PRED, 0, "en0_pred_held");
    settle();
    en = 1'b1;
    set_slots(64'h100, 64'h0, 64'h3F, 64'h1234);
    expect_out(SEL_PRED, 0, "init_pred_all0");
    settle();

    // Counter saturation with history held at zero.
    set_slots(64'h100, 64'h100, 64'h100, 64'h100);
    upd(64'h100, 1'b1, 1'b1, 1'b1, 4'h0, 4'hF, "ctr_t1");
    upd(64'h100, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, "ctr_t2");
    upd(64'h100, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, "ctr_t3");
    upd(64'h100, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF, "ctr_n1");
    upd(64'h100, 1'b0, 1'b1, 1'b1, 4'hF, 4'h0, "ctr_n2");
    upd(64'h100, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, "ctr_n3");
    upd(64'h100, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, "ctr_n4");
    upd(64'h100, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, "ctr_t4");
    upd(64'h100, 1'b1, 1'b1, 1'b1, 4'h0, 4'hF, "ctr_t5");

    // History T,N,T,T on address 0 builds ghr = 4'b1011.
    upd(64'h0, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, "ghr_c1");
    upd(64'h0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, "ghr_c2");
    upd(64'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, "ghr_c3");
    upd(64'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, "ghr_c4");
    settle();
    set_slots(64'h38, 64'h24, 64'h2C, 64'h28);
    expect_out(SEL_PRED, 4'b0111, "ghr_1011_pred");
    upd(64'h0, 1'b1, 1'b0, 1'b0, 4'b0111, 4'b0000, "ghr_c5");
    settle();
    set_slots(64'h30, 64'h0, 64'h1C, 64'h18);
    expect_out(SEL_PRED, 4'b0101, "ghr_wr_idx44");

    // History clear coinciding with a taken drain.
    upd(64'h0, 1'b1, 1'b0, 1'b1, 4'b0101, 4'b0110, "hclr_drain");
    hist_clr = 1'b0;

    // Reset in the middle of operation.
    commit_v    = 4'b0011;
    commit_takb = 4'b0000;
    commit_ip[0] = 64'h100;
    commit_ip[1] = 64'h100;
    step();
    commit_v = '0;
    expect_out(SEL_QCNT, 2, "pre_rst_q2");
    expect_out(SEL_OVF,  6, "pre_rst_ovf6");
    settle();
    rst_n = 1'b0;
    expect_out(SEL_READY, 0, "midrst_ready");
    expect_out(SEL_QCNT,  0, "midrst_qcount");
    expect_out(SEL_OVF,   0, "midrst_ovf");
    expect_out(SEL_PRED,  0, "midrst_pred");
    settle();

    n_checks++;
    if (ready == 1'b0) n_pass++;
    else $display("FAIL midrst_ready_direct: got 0x%0h expected 0x0", ready);
    n_checks++;
    if (q_count == '0) n_pass++;
    else $display("FAIL midrst_qcount_direct: got 0x%0h expected 0x0", q_count);
    n_checks++;
    if (ovf_cnt == 16'd0) n_pass++;
    else $display("FAIL midrst_ovf_direct: got 0x%0h expected 0x0", ovf_cnt);
    n_checks++;
    if (predict_taken == '0) n_pass++;
    else $display("FAIL midrst_pred_direct: got 0x%0h expected 0x0", predict_taken);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass != n_checks || sb.size() != 0) begin
      $display("FAIL summary: got %0d passed expected %0d", n_pass, n_checks);
      $fatal(1);
    end
    $finish;
  end

endmodule
